// File: rtl/count_enable_gen.sv
// Purpose: programmable enable-pulse generator feeding the downstream counter's enable input.
// Latency: first enable in RUN cycle div (one cycle after start is sampled starts RUN).
// Backpressure: none; start/stop are level requests sampled only in IDLE/RUN respectively.
//
// Port summary:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_start        run request (IDLE only)
//   i_stop         abort request (RUN only)
//   i_mode         0 = continuous, 1 = burst (captured at start)
//   i_div          enable period minus one (captured at start)
//   i_burst_len    pulses per burst (captured at start)
//   i_pause        hold divider/count, mask enable (only with COUNT_ENABLE_GEN_PAUSE_EN)
//   o_enb          one-cycle enable pulse
//   o_busy         high while running
//   o_done         one-cycle pulse when a burst completes
//   o_tick_cnt     pulses issued in the current or last run
//
// Optional feature macro: COUNT_ENABLE_GEN_PAUSE_EN adds the i_pause input.

module count_enable_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_mode,
  input  logic [DIV_W-1:0]   i_div,
  input  logic [BURST_W-1:0] i_burst_len,
`ifdef COUNT_ENABLE_GEN_PAUSE_EN
  input  logic               i_pause,
`endif
  output logic               o_enb,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_tick_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [BURST_W-1:0] r_burst_len;
  logic [BURST_W-1:0] r_tick_cnt;

  logic               w_pause;
  logic               w_div_zero;
  logic               w_enb;
  logic [BURST_W-1:0] w_tick_nxt;
  logic               w_last;

`ifdef COUNT_ENABLE_GEN_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_div_zero = (r_div_cnt == '0);
  // Pause masks the pulse in the same cycle; without the pause feature this
  // is purely a decode of registered state.
  assign w_enb      = (r_state == S_RUN) && w_div_zero && !w_pause;
  assign w_tick_nxt = r_tick_cnt + 1'b1;
  // The pulse being issued now is the final one of the burst.
  assign w_last     = r_mode && (w_tick_nxt == r_burst_len);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_burst_len <= '0;
      r_tick_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_div       <= i_div;
            r_burst_len <= i_burst_len;
            r_div_cnt   <= i_div;
            r_tick_cnt  <= '0;
            // An empty burst skips RUN entirely and just reports done.
            r_state     <= (i_mode && (i_burst_len == '0)) ? S_FINISH : S_RUN;
          end
        end
        S_RUN: begin
          // A pulse shown this cycle counts even when stop aborts the run.
          if (w_enb) begin
            r_tick_cnt <= w_tick_nxt;
          end
          if (i_stop) begin
            r_state <= S_IDLE;
          end else if (w_pause) begin
            r_div_cnt <= r_div_cnt;
          end else if (w_div_zero) begin
            r_div_cnt <= r_div;
            if (w_last) begin
              r_state <= S_FINISH;
            end
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_enb      = w_enb;
  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_FINISH);
  assign o_tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_count_enable_gen.sv
// Purpose: self-checking bench for count_enable_gen using per-cycle vector tables.
// Latency: vectors give expected outputs for the cycle in which their inputs are applied.
// Backpressure: not applicable.

module tb_count_enable_gen;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_stop;
  logic       i_mode;
  logic [7:0] i_div;
  logic [7:0] i_burst_len;
`ifdef COUNT_ENABLE_GEN_PAUSE_EN
  logic       i_pause;
`endif
  logic       o_enb;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_tick_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  count_enable_gen #(.DIV_W(8), .BURST_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .i_div       (i_div),
    .i_burst_len (i_burst_len),
`ifdef COUNT_ENABLE_GEN_PAUSE_EN
    .i_pause     (i_pause),
`endif
    .o_enb       (o_enb),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_tick_cnt  (o_tick_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] div;
    logic [7:0] blen;
    logic       enb;
    logic       busy;
    logic       done;
    logic [7:0] tick;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic st, input logic sp, input logic md, input logic [7:0] dv,
                   input logic [7:0] bl, input logic e, input logic b, input logic d,
                   input logic [7:0] t);
    vec_t x;
    x.start = st; x.stop = sp; x.mode = md; x.div = dv; x.blen = bl;
    x.enb = e; x.busy = b; x.done = d; x.tick = t;
    vecs.push_back(x);
  endtask

  // Compares {enb,busy,done,tick_cnt} packed as 11 bits.
  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got enb/busy/done/tick=%b/%b/%b/%0d expected %b/%b/%b/%0d",
               name, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [10:0] outs();
    return {o_enb, o_busy, o_done, o_tick_cnt};
  endfunction

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0;
    i_div = '0; i_burst_len = '0;
`ifdef COUNT_ENABLE_GEN_PAUSE_EN
    i_pause = 1'b0;
`endif

    // Burst div=2 len=4, with a restart attempt carrying new params mid-run
    // and a start request during FINISH.
    v(1,0,1,2,4, 0,0,0,0);
    v(0,0,1,2,4, 0,1,0,0);
    v(1,0,1,7,9, 0,1,0,0);
    v(0,0,0,7,9, 1,1,0,0);
    v(0,0,0,7,9, 0,1,0,1);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 1,1,0,1);
    v(0,0,0,0,0, 0,1,0,2);
    v(0,0,0,0,0, 0,1,0,2);
    v(0,0,0,0,0, 1,1,0,2);
    v(0,0,0,0,0, 0,1,0,3);
    v(0,0,0,0,0, 0,1,0,3);
    v(0,0,0,0,0, 1,1,0,3);
    v(1,0,0,0,0, 0,0,1,4);
    v(0,0,0,0,0, 0,0,0,4);
    v(0,0,0,0,0, 0,0,0,4);
    // Continuous div=0, stop in the tenth RUN cycle; stop in IDLE ignored.
    v(1,0,0,0,0, 0,0,0,4);
    v(0,0,0,0,0, 1,1,0,0);
    v(0,0,0,0,0, 1,1,0,1);
    v(0,0,0,0,0, 1,1,0,2);
    v(0,0,0,0,0, 1,1,0,3);
    v(0,0,0,0,0, 1,1,0,4);
    v(0,0,0,0,0, 1,1,0,5);
    v(0,0,0,0,0, 1,1,0,6);
    v(0,0,0,0,0, 1,1,0,7);
    v(0,0,0,0,0, 1,1,0,8);
    v(0,1,0,0,0, 1,1,0,9);
    v(0,0,0,0,0, 0,0,0,10);
    v(0,1,0,0,0, 0,0,0,10);
    // Empty burst: done once, busy never, tick cleared.
    v(1,0,1,5,0, 0,0,0,10);
    v(0,0,0,0,0, 0,0,1,0);
    v(0,0,0,0,0, 0,0,0,0);
    v(0,0,0,0,0, 0,0,0,0);
    // Stop on the final pulse of a 3-pulse burst: no done.
    v(1,0,1,0,3, 0,0,0,0);
    v(0,0,1,0,3, 1,1,0,0);
    v(0,0,1,0,3, 1,1,0,1);
    v(0,1,1,0,3, 1,1,0,2);
    v(0,0,0,0,0, 0,0,0,3);
    v(0,0,0,0,0, 0,0,0,3);

    #2;
    chk("reset_state", outs(), 11'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge i_clk);
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].enb, vecs[i].busy, vecs[i].done, vecs[i].tick});
      i_start = vecs[i].start; i_stop = vecs[i].stop; i_mode = vecs[i].mode;
      i_div = vecs[i].div; i_burst_len = vecs[i].blen;
    end

    // Asynchronous reset mid-burst (div=3, len=5): one pulse issued by cycle 4.
    @(negedge i_clk);
    i_start = 1'b1; i_stop = 1'b0; i_mode = 1'b1; i_div = 8'd3; i_burst_len = 8'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("rst_pre_c0", outs(), {1'b0, 1'b1, 1'b0, 8'd0});
    for (int c = 1; c <= 4; c++) @(negedge i_clk);
    chk("rst_pre_c4", outs(), {1'b0, 1'b1, 1'b0, 8'd1});
    #2 i_rst = 1'b0;
    #1 chk("rst_immediate", outs(), 11'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      chk($sformatf("rst_after%0d", c), outs(), 11'd0);
    end

`ifdef COUNT_ENABLE_GEN_PAUSE_EN
    // Pause cycles 2..5 of a div=1, len=3 burst: pulses move from 1,3,5 to 1,7,9.
    @(negedge i_clk);
    i_start = 1'b1; i_mode = 1'b1; i_div = 8'd1; i_burst_len = 8'd3;
    for (int c = 0; c <= 11; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_pause = (c >= 2 && c <= 5);
      #1;
      chk($sformatf("pause_c%0d", c), {o_enb, o_busy, o_done, 8'd0},
          {(c == 1 || c == 7 || c == 9), (c <= 9), (c == 10), 8'd0});
    end
    i_pause = 1'b0;
    chk("pause_tick", {3'b0, o_tick_cnt}, {3'b0, 8'd3});
`endif

    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_enable_gen.md
# count_enable_gen

Programmable enable-pulse generator that drives the `enb` input of the free-running `counter` stage directly downstream. It divides `clk` by a configured ratio and issues either a continuous enable stream or a fixed-length burst of enable pulses, with start/stop control and a busy/done handshake toward the controlling agent. All run parameters are captured at start, so the downstream counter sees a deterministic pulse train.

## Interface
- `DIV_W`, 8: width of the divider setting.
- `BURST_W`, 8: width of the burst length and the issued-pulse counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `stop`  in  1  abort request; sampled only in RUN.
- `mode`  in  1  0 = continuous, 1 = burst; captured at start.
- `div`  in  DIV_W  period select, enable period = `div`+1 cycles; captured at start.
- `burst_len`  in  BURST_W  number of pulses in burst mode; captured at start.
- `enb`  out  1  enable pulse to the counter, one cycle wide.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on burst completion.
- `tick_cnt`  out  BURST_W  pulses issued in the current or last run.

## Operation
- States: IDLE, RUN, FINISH. All outputs are Moore decodes of registered state, with no combinational path from inputs to outputs.
- IDLE: `start`=1 captures `mode`, `div` and `burst_len`, loads the divider with `div`, clears `tick_cnt` and goes to RUN. Exception: burst mode with `burst_len`=0 goes straight to FINISH and issues no pulses.
- RUN: `enb`=1 when the divider is 0. On that edge the divider reloads `div` and `tick_cnt` increments. Otherwise the divider decrements.
- Burst mode: on the edge that issues pulse number `burst_len`, go to FINISH.
- Continuous mode: runs until `stop`. `tick_cnt` wraps modulo 2^BURST_W.
- `stop`=1 in RUN: go to IDLE next edge with no `done`. `stop` has priority over burst completion in the same cycle. The `enb` already shown in that cycle still counts in `tick_cnt`.
- FINISH: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `start` outside IDLE and `stop` outside RUN are ignored. Input changes during RUN have no effect.
- `tick_cnt` holds its value after a run until the next accepted `start`.
- Reset (asynchronous, any state): state IDLE, divider 0, `tick_cnt` 0, `enb`/`busy`/`done` 0. Takes effect immediately, mid-burst included.

## Timing
- Cycle 0 is the first cycle with `busy`=1, i.e. the cycle after `start` is sampled.
- Pulses fall in RUN cycles `div`, 2·`div`+1, …, k·(`div`+1)−1.
- `div`=0 gives `enb` in every RUN cycle.
- Burst of N pulses: last `enb` in cycle N·(`div`+1)−1. `done` follows in the next cycle; IDLE the cycle after that.
- Earliest restart: `start` sampled in the first IDLE cycle after FINISH.
- `burst_len`=0: `done` in the cycle after `start` is sampled; `busy` never asserts.

## Configuration
- Macro `COUNT_ENABLE_GEN_PAUSE_EN` defined: adds input port `pause` (1 bit).
  - While `pause`=1 in RUN, the divider and `tick_cnt` hold and `enb` is forced to 0. `busy` stays 1.
  - `stop` still aborts during pause.
  - Pulses resume from the held divider value.
- Macro undefined: no `pause` port and no hold logic; behaviour is exactly as described above.

## Test plan
- Reset: drive `rst`=0 mid-burst (`div`=3, `burst_len`=5) → `enb`, `busy`, `done` and `tick_cnt` go to 0 immediately; after release, no pulse until a new `start`.
- Burst: `mode`=1, `div`=2, `burst_len`=4, `start` → `enb` in cycles 2, 5, 8, 11; `done` in cycle 12; `tick_cnt`=4; `busy` high cycles 0–11.
- Continuous: `mode`=0, `div`=0, `start`, `stop` after 10 cycles → `enb` every cycle; `tick_cnt`=10 or 11 depending on the stop cycle; no `done`.
- Boundary: `burst_len`=0 → no `enb`, `busy` never 1, `done` pulses once. `stop` on the last burst pulse → no `done`.
- Capture: change `div` 2→7 and pulse `start` during RUN → pulse spacing unchanged at 3 cycles; second `start` ignored.
- Pause (macro on): `div`=1, `burst_len`=3, `pause` high 4 cycles after the first `enb` → pulse train delayed by 4 cycles; exactly 3 `enb`, then `done`.
